// File: rtl/ip_psram_pattern_tester.sv
// PSRAM pattern tester: writes a pattern over the whole address range of each channel,
// reads it back and compares it, then reports per-channel error statistics over the UART.
module ip_psram_pattern_tester #(
    parameter int          CHANNELS = 2,
    parameter int          ADDR_W   = 22,
    parameter logic [7:0]  SEED     = 8'hA5,
    parameter int          TIMEOUT  = 255
) (
    input  logic                         clk,
    input  logic                         n_reset,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic                         initial_busy,
    output logic [CHANNELS-1:0]          rd,
    output logic [CHANNELS-1:0]          wr,
    input  logic [CHANNELS-1:0]          busy,
    output logic [CHANNELS*ADDR_W-1:0]   address,
    output logic [CHANNELS*8-1:0]        wdata,
    input  logic [CHANNELS*8-1:0]        rdata,
    input  logic [CHANNELS-1:0]          rdata_en,
    output logic [7:0]                   send_data,
    output logic                         send_req,
    input  logic                         send_busy,
    output logic [2:0]                   state,
    output logic                         done,
    output logic                         pass
);
    localparam int                CH_W     = 1;
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(CHANNELS - 1);
    localparam logic [7:0]        TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_INIT = 3'd1,
        WRITE     = 3'd2,
        READ      = 3'd3,
        RDWAIT    = 3'd4,
        REPORT    = 3'd5,
        NEXT      = 3'd6,
        DONE      = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch;
    logic [ADDR_W-1:0]   addr, req_addr;
    logic [7:0]          lfsr, req_data, exp_data;
    logic [1:0]          mode_q;
    logic [23:0]         err, fa;
    logic                fail;
    logic                req_rd, req_wr;
    logic [7:0]          tmo;
    logic [2:0]          byte_idx;
    logic                send_gap, send_req_q, done_q, pass_q;
    logic [7:0]          send_data_q;

    logic                ch_busy, ch_en, req_prev, can_issue, wr_acc, rd_acc;
    logic                tmo_hit, rd_done, rd_bad, last_addr, last_ch, send_ok;
    logic [7:0]          ch_rdata, pattern, lfsr_nxt, tx_byte;
    logic [15:0]         a16;
    logic [23:0]         a24, fa_rep;

    assign ch_busy   = busy[ch];
    assign ch_en     = rdata_en[ch];
    assign ch_rdata  = rdata[8*ch +: 8];
    assign req_prev  = req_rd | req_wr;
    assign can_issue = !ch_busy && !req_prev;
    assign wr_acc    = req_wr && !ch_busy;
    assign rd_acc    = req_rd && !ch_busy;
    assign tmo_hit   = (tmo == TMO_LAST) && !ch_en;
    assign rd_done   = (state_q == RDWAIT) && (ch_en || tmo_hit);
    assign rd_bad    = ch_en ? (ch_rdata != exp_data) : 1'b1;
    assign last_addr = &addr;
    assign last_ch   = (ch == LAST_CH);
    assign send_ok   = (state_q == REPORT) && !send_req_q && !send_gap && !send_busy;
    assign fa_rep    = (err == 24'd0) ? 24'hFFFFFF : fa;
    assign lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // Zero-extended views of the address; missing high bits read as 0 for narrow ADDR_W.
    always_comb begin
        a16 = '0;
        a24 = '0;
        for (int b = 0; b < ADDR_W && b < 24; b++) begin
            a24[b] = addr[b];
            if (b < 16) a16[b] = addr[b];
        end
    end

    always_comb begin
        pattern = a16[7:0];
        case (mode_q)
            2'd0: pattern = a16[7:0];
            2'd1: pattern = ~a16[7:0];
            2'd2: pattern = lfsr;
            2'd3: pattern = a16[7:0] ^ a16[15:8];
            default: pattern = a16[7:0];
        endcase
    end

    always_comb begin
        tx_byte = 8'h43;
        case (byte_idx)
            3'd0: tx_byte = 8'h43;
            3'd1: tx_byte = 8'(ch);
            3'd2: tx_byte = err[23:16];
            3'd3: tx_byte = err[15:8];
            3'd4: tx_byte = err[7:0];
            3'd5: tx_byte = fa_rep[23:16];
            3'd6: tx_byte = fa_rep[15:8];
            3'd7: tx_byte = fa_rep[7:0];
            default: tx_byte = 8'h43;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = WAIT_INIT;
            WAIT_INIT:  if (!initial_busy) state_d = WRITE;
            WRITE:      if (wr_acc && last_addr) state_d = READ;
            READ:       if (rd_acc) state_d = RDWAIT;
            RDWAIT:     if (rd_done) state_d = last_addr ? REPORT : READ;
            // byte_idx wraps to 0 exactly when the eighth byte is on the wire
            REPORT:     if (send_req_q && byte_idx == 3'd0) state_d = NEXT;
            NEXT:       state_d = last_ch ? DONE : WAIT_INIT;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            ch          <= '0;
            addr        <= '0;
            req_addr    <= '0;
            lfsr        <= '0;
            req_data    <= '0;
            exp_data    <= '0;
            mode_q      <= '0;
            err         <= '0;
            fa          <= '0;
            fail        <= 1'b0;
            req_rd      <= 1'b0;
            req_wr      <= 1'b0;
            tmo         <= '0;
            byte_idx    <= '0;
            send_gap    <= 1'b0;
            send_req_q  <= 1'b0;
            send_data_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_rd     <= 1'b0;
            req_wr     <= 1'b0;
            send_req_q <= 1'b0;
            send_gap   <= send_req_q;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mode_q   <= mode;
                        ch       <= '0;
                        err      <= '0;
                        fa       <= '0;
                        fail     <= 1'b0;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                        byte_idx <= '0;
                    end
                end
                WAIT_INIT: begin
                    if (!initial_busy) begin
                        addr <= '0;
                        lfsr <= SEED;
                    end
                end
                WRITE: begin
                    if (wr_acc) begin
                        addr <= addr + 1'b1;
                        lfsr <= last_addr ? SEED : lfsr_nxt;
                    end else if (can_issue) begin
                        req_wr   <= 1'b1;
                        req_addr <= addr;
                        req_data <= pattern;
                    end
                end
                READ: begin
                    if (rd_acc) begin
                        lfsr <= lfsr_nxt;
                        tmo  <= '0;
                    end else if (can_issue) begin
                        req_rd   <= 1'b1;
                        req_addr <= addr;
                        exp_data <= pattern;
                    end
                end
                RDWAIT: begin
                    tmo <= tmo + 8'd1;
                    if (rd_done) begin
                        if (rd_bad) begin
                            if (err != 24'hFFFFFF) err <= err + 24'd1;
                            if (err == 24'd0) fa <= a24;
                        end
                        addr <= addr + 1'b1;
                    end
                end
                REPORT: begin
                    if (send_ok) begin
                        send_req_q  <= 1'b1;
                        send_data_q <= tx_byte;
                        byte_idx    <= byte_idx + 3'd1;
                    end
                end
                NEXT: begin
                    fail     <= fail | (err != 24'd0);
                    err      <= '0;
                    fa       <= '0;
                    req_addr <= '0;
                    req_data <= '0;
                    if (last_ch) begin
                        done_q <= 1'b1;
                        pass_q <= !(fail || (err != 24'd0));
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Only the channel under test sees requests; the others are held at 0.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic sel;
        assign sel                          = (ch == CH_W'(i));
        assign rd[i]                        = req_rd & sel;
        assign wr[i]                        = req_wr & sel;
        assign address[i*ADDR_W +: ADDR_W]  = sel ? req_addr : '0;
        assign wdata[i*8 +: 8]              = sel ? req_data : '0;
    end

    assign send_data = send_data_q;
    assign send_req  = send_req_q;
    assign state     = state_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_ip_psram_pattern_tester.sv
// Bench for ip_psram_pattern_tester: PSRAM + UART models, scoreboard of writes and report bytes.
module tb_ip_psram_pattern_tester;
    localparam int         CH   = 2;
    localparam int         AW   = 4;
    localparam int         TMO  = 8;
    localparam logic [7:0] SEED = 8'hA5;

    logic               clk = 1'b0;
    logic               n_reset = 1'b0;
    logic               start = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic               initial_busy = 1'b0;
    logic [CH-1:0]      rd, wr, rdata_en;
    logic [CH-1:0]      busy = '0;
    logic [CH*AW-1:0]   address;
    logic [CH*8-1:0]    wdata, rdata;
    logic [7:0]         send_data;
    logic               send_req;
    logic               send_busy;
    logic [2:0]         state;
    logic               done, pass;

    ip_psram_pattern_tester #(
        .CHANNELS(CH), .ADDR_W(AW), .SEED(SEED), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .mode(mode),
        .initial_busy(initial_busy), .rd(rd), .wr(wr), .busy(busy),
        .address(address), .wdata(wdata), .rdata(rdata), .rdata_en(rdata_en),
        .send_data(send_data), .send_req(send_req), .send_busy(send_busy),
        .state(state), .done(done), .pass(pass)
    );

    always #5 clk = ~clk;

    // PSRAM model: zero-wait, optional corruption (ch0) and per-channel silence.
    logic [7:0]  mem [CH][16];
    logic [15:0] corrupt0 = '0;
    logic [CH-1:0] no_resp = '0;

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rdata_en <= '0;
            rdata    <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                rdata_en[c] <= 1'b0;
                if (wr[c] && !busy[c]) mem[c][address[c*AW +: AW]] <= wdata[c*8 +: 8];
                if (rd[c] && !busy[c] && !no_resp[c]) begin
                    rdata_en[c]     <= 1'b1;
                    rdata[c*8 +: 8] <= mem[c][address[c*AW +: AW]]
                                       ^ ((c == 0 && corrupt0[address[c*AW +: AW]]) ? 8'h3C : 8'h00);
                end
            end
        end
    end

    // UART model: busy for uart_hold cycles after each send_req.
    int uart_hold = 1;
    int ucnt;
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset)         ucnt <= 0;
        else if (send_req)    ucnt <= uart_hold;
        else if (ucnt != 0)   ucnt <= ucnt - 1;
    end
    assign send_busy = (ucnt != 0);

    // Monitor: records observed traffic and protocol violations.
    logic [15:0] obs_wr[$];
    logic [7:0]  obs_byte[$];
    int          n_rd = 0, viol_init = 0, viol_pulse = 0, viol_uart = 0;
    logic        prev_req = 1'b0, pend = 1'b0, seen_low = 1'b0;

    always @(negedge clk) begin
        if (n_reset) begin
            for (int c = 0; c < CH; c++)
                if (wr[c]) obs_wr.push_back({4'(c), address[c*AW +: AW], wdata[c*8 +: 8]});
            if (|rd) n_rd <= n_rd + 1;
            if ((|rd || |wr) && initial_busy) viol_init <= viol_init + 1;
            if ((|rd || |wr) && prev_req) viol_pulse <= viol_pulse + 1;
            prev_req <= |rd || |wr;
            if (send_req) begin
                obs_byte.push_back(send_data);
                if (send_busy || (pend && !seen_low)) viol_uart <= viol_uart + 1;
                pend     <= 1'b1;
                seen_low <= 1'b0;
            end else if (!send_busy) begin
                seen_low <= 1'b1;
            end
        end
    end

    // Scoreboard
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_byte[$];
    logic        exp_pass;
    int          ncmp = 0, nfail = 0;
    int          wr_base, byte_base;
    logic [15:0] ew;
    logic [7:0]  eb;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [7:0] exp_pat(input logic [1:0] m, input int a, input logic [7:0] l);
        case (m)
            2'd0: return a[7:0];
            2'd1: return ~a[7:0];
            2'd2: return l;
            default: return a[7:0] ^ a[15:8];
        endcase
    endfunction

    task automatic push_expected(input logic [1:0] m);
        logic [7:0]  l;
        logic [23:0] errs, fa;
        logic        bad;
        exp_pass = 1'b1;
        for (int c = 0; c < CH; c++) begin
            l = SEED;
            errs = 0;
            fa = 0;
            for (int a = 0; a < 16; a++) begin
                exp_wr.push_back({4'(c), 4'(a), exp_pat(m, a, l)});
                l = lfsr_step(l);
                bad = no_resp[c] || (c == 0 && corrupt0[a]);
                if (bad) begin
                    if (errs == 0) fa = 24'(a);
                    errs++;
                end
            end
            if (errs == 0) fa = 24'hFFFFFF;
            else exp_pass = 1'b0;
            exp_byte.push_back(8'h43);
            exp_byte.push_back(8'(c));
            exp_byte.push_back(errs[23:16]);
            exp_byte.push_back(errs[15:8]);
            exp_byte.push_back(errs[7:0]);
            exp_byte.push_back(fa[23:16]);
            exp_byte.push_back(fa[15:8]);
            exp_byte.push_back(fa[7:0]);
        end
    endtask

    task automatic do_start(input logic [1:0] m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        ncmp++;
        if ({rd, wr, address, wdata, send_req, send_data, state, done, pass} !== '0) begin
            nfail++;
            $display("FAIL reset_outputs: got state=%0d rd=%b wr=%b addr=%h wdata=%h sreq=%b done=%b pass=%b, required all 0",
                     state, rd, wr, address, wdata, send_req, done, pass);
        end
        @(negedge clk);
        n_reset = 1'b1;
        repeat (3) @(negedge clk);
        ncmp++;
        if (state !== 3'd0 || done !== 1'b0 || pass !== 1'b0) begin
            nfail++;
            $display("FAIL idle_after_reset: got state=%0d done=%b pass=%b, required 0/0/0", state, done, pass);
        end
    endtask

    task automatic test_mode0_clean;
        wr_base = obs_wr.size(); byte_base = obs_byte.size();
        corrupt0 = '0; no_resp = '0;
        push_expected(2'd0);
        do_start(2'd0);
        repeat (20) @(negedge clk);
        do_start(2'd1);   // mid-run start must be ignored
        for (int i = 0; i < 4000 && !done; i++) @(negedge clk);
        ncmp++;
        if (done !== 1'b1 || state !== 3'd7) begin
            nfail++; $display("FAIL m0_done: got done=%b state=%0d, required 1/7", done, state);
        end
        ncmp++;
        if (pass !== exp_pass) begin nfail++; $display("FAIL m0_pass: got %b required %b", pass, exp_pass); end
        ncmp++;
        if (n_rd !== 32 || viol_pulse !== 0) begin
            nfail++; $display("FAIL m0_reads: got %0d reads %0d back-to-back, required 32/0", n_rd, viol_pulse);
        end
        for (int i = 0; exp_wr.size() > 0; i++) begin
            ew = exp_wr.pop_front(); ncmp++;
            if (wr_base + i >= obs_wr.size() || obs_wr[wr_base + i] !== ew) begin
                nfail++; $display("FAIL m0_write[%0d]: got %h required %h", i,
                                  (wr_base + i < obs_wr.size()) ? obs_wr[wr_base + i] : 16'hxxxx, ew);
            end
        end
        for (int i = 0; exp_byte.size() > 0; i++) begin
            eb = exp_byte.pop_front(); ncmp++;
            if (byte_base + i >= obs_byte.size() || obs_byte[byte_base + i] !== eb) begin
                nfail++; $display("FAIL m0_byte[%0d]: got %h required %h", i,
                                  (byte_base + i < obs_byte.size()) ? obs_byte[byte_base + i] : 8'hxx, eb);
            end
        end
    endtask

    task automatic test_corrupt;
        wr_base = obs_wr.size(); byte_base = obs_byte.size();
        corrupt0 = 16'h0220; no_resp = '0;   // addresses 5 and 9
        push_expected(2'd0);
        do_start(2'd0);
        for (int i = 0; i < 4000 && !done; i++) @(negedge clk);
        ncmp++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            nfail++; $display("FAIL corrupt_pass: got done=%b pass=%b, required 1/0", done, pass);
        end
        for (int i = 0; exp_wr.size() > 0; i++) begin
            ew = exp_wr.pop_front(); ncmp++;
            if (wr_base + i >= obs_wr.size() || obs_wr[wr_base + i] !== ew) begin
                nfail++; $display("FAIL corrupt_write[%0d]: required %h", i, ew);
            end
        end
        for (int i = 0; exp_byte.size() > 0; i++) begin
            eb = exp_byte.pop_front(); ncmp++;
            if (byte_base + i >= obs_byte.size() || obs_byte[byte_base + i] !== eb) begin
                nfail++; $display("FAIL corrupt_byte[%0d]: got %h required %h", i,
                                  (byte_base + i < obs_byte.size()) ? obs_byte[byte_base + i] : 8'hxx, eb);
            end
        end
        corrupt0 = '0;
    endtask

    task automatic test_lfsr;
        wr_base = obs_wr.size(); byte_base = obs_byte.size();
        push_expected(2'd2);
        do_start(2'd2);
        for (int i = 0; i < 4000 && !done; i++) @(negedge clk);
        ncmp++;
        if (obs_wr.size() < wr_base + 2 || obs_wr[wr_base][7:0] !== 8'hA5 || obs_wr[wr_base + 1][7:0] !== 8'h4A) begin
            nfail++; $display("FAIL lfsr_first: required A5 then 4A");
        end
        ncmp++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            nfail++; $display("FAIL lfsr_pass: got done=%b pass=%b, required 1/1", done, pass);
        end
        for (int i = 0; exp_wr.size() > 0; i++) begin
            ew = exp_wr.pop_front(); ncmp++;
            if (wr_base + i >= obs_wr.size() || obs_wr[wr_base + i] !== ew) begin
                nfail++; $display("FAIL lfsr_write[%0d]: required %h", i, ew);
            end
        end
        for (int i = 0; exp_byte.size() > 0; i++) begin
            eb = exp_byte.pop_front(); ncmp++;
            if (byte_base + i >= obs_byte.size() || obs_byte[byte_base + i] !== eb) begin
                nfail++; $display("FAIL lfsr_byte[%0d]: required %h", i, eb);
            end
        end
    endtask

    task automatic test_timeout;
        wr_base = obs_wr.size(); byte_base = obs_byte.size();
        no_resp = 2'b10;
        push_expected(2'd1);
        do_start(2'd1);
        for (int i = 0; i < 6000 && !done; i++) @(negedge clk);
        ncmp++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            nfail++; $display("FAIL timeout_pass: got done=%b pass=%b, required 1/0", done, pass);
        end
        for (int i = 0; exp_wr.size() > 0; i++) begin
            ew = exp_wr.pop_front(); ncmp++;
            if (wr_base + i >= obs_wr.size() || obs_wr[wr_base + i] !== ew) begin
                nfail++; $display("FAIL timeout_write[%0d]: required %h", i, ew);
            end
        end
        for (int i = 0; exp_byte.size() > 0; i++) begin
            eb = exp_byte.pop_front(); ncmp++;
            if (byte_base + i >= obs_byte.size() || obs_byte[byte_base + i] !== eb) begin
                nfail++; $display("FAIL timeout_byte[%0d]: got %h required %h", i,
                                  (byte_base + i < obs_byte.size()) ? obs_byte[byte_base + i] : 8'hxx, eb);
            end
        end
        no_resp = '0;
    endtask

    task automatic test_init_uart;
        int vi0, vu0;
        wr_base = obs_wr.size(); byte_base = obs_byte.size();
        vi0 = viol_init; vu0 = viol_uart;
        uart_hold = 20;
        initial_busy = 1'b1;
        push_expected(2'd3);
        do_start(2'd3);
        repeat (100) @(negedge clk);
        ncmp++;
        if (obs_wr.size() != wr_base || state !== 3'd1) begin
            nfail++; $display("FAIL init_hold: got %0d writes state=%0d, required 0/1", obs_wr.size() - wr_base, state);
        end
        initial_busy = 1'b0;
        for (int i = 0; i < 8000 && !done; i++) @(negedge clk);
        ncmp++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            nfail++; $display("FAIL init_pass: got done=%b pass=%b, required 1/1", done, pass);
        end
        ncmp++;
        if (viol_init != vi0 || viol_uart != vu0) begin
            nfail++; $display("FAIL init_protocol: got %0d init / %0d uart violations, required 0/0",
                              viol_init - vi0, viol_uart - vu0);
        end
        for (int i = 0; exp_wr.size() > 0; i++) begin
            ew = exp_wr.pop_front(); ncmp++;
            if (wr_base + i >= obs_wr.size() || obs_wr[wr_base + i] !== ew) begin
                nfail++; $display("FAIL init_write[%0d]: required %h", i, ew);
            end
        end
        for (int i = 0; exp_byte.size() > 0; i++) begin
            eb = exp_byte.pop_front(); ncmp++;
            if (byte_base + i >= obs_byte.size() || obs_byte[byte_base + i] !== eb) begin
                nfail++; $display("FAIL init_byte[%0d]: got %h required %h", i,
                                  (byte_base + i < obs_byte.size()) ? obs_byte[byte_base + i] : 8'hxx, eb);
            end
        end
        uart_hold = 1;
    endtask

    task automatic test_reset_mid;
        bit hit;
        hit = 1'b0;
        do_start(2'd0);
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = wr[0] && (address[AW-1:0] == 4'd7);
        end
        ncmp++;
        if (!hit) begin nfail++; $display("FAIL midreset_reach: write at address 7 not seen within 200 cycles"); end
        #2 n_reset = 1'b0;
        #1;
        ncmp++;
        if ({rd, wr, address, wdata, send_req, send_data, state, done, pass} !== '0) begin
            nfail++; $display("FAIL midreset_outputs: got state=%0d wr=%b addr=%h wdata=%h, required all 0",
                              state, wr, address, wdata);
        end
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        wr_base = obs_wr.size(); byte_base = obs_byte.size();
        push_expected(2'd0);
        do_start(2'd0);
        for (int i = 0; i < 4000 && !done; i++) @(negedge clk);
        ncmp++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            nfail++; $display("FAIL midreset_pass: got done=%b pass=%b, required 1/1", done, pass);
        end
        for (int i = 0; exp_wr.size() > 0; i++) begin
            ew = exp_wr.pop_front(); ncmp++;
            if (wr_base + i >= obs_wr.size() || obs_wr[wr_base + i] !== ew) begin
                nfail++; $display("FAIL midreset_write[%0d]: got %h required %h", i,
                                  (wr_base + i < obs_wr.size()) ? obs_wr[wr_base + i] : 16'hxxxx, ew);
            end
        end
        for (int i = 0; exp_byte.size() > 0; i++) begin
            eb = exp_byte.pop_front(); ncmp++;
            if (byte_base + i >= obs_byte.size() || obs_byte[byte_base + i] !== eb) begin
                nfail++; $display("FAIL midreset_byte[%0d]: required %h", i, eb);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        test_mode0_clean;
        test_corrupt;
        test_lfsr;
        test_timeout;
        test_init_uart;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
